raster_sequencer: RTL and testbench
===================================

Name: raster_sequencer

Overview:
- Queues triangle commands and issues them one at a time to the rasterizer through a start/done handshake.
- Replaces the fixed single-triangle start logic in the top level.
- Sits between the command source (host/geometry stage) and rasterizer_unit, in the gpu_clk_150 domain.
- Adds a parametrised command FIFO, frame-end marking, progress counters and an optional hang watchdog.

Parameters:
COORD_W, 32, width of one coordinate (IEEE-754 single by default)
DEPTH, 8, command FIFO entries (power of 2, >=2)
CNT_W, 16, width of the completed-triangle counter
TIMEOUT_CYCLES, 1048576, watchdog limit in clk cycles (used only with the optional feature)

Ports:
clk  in  1  GPU clock
areset  in  1  asynchronous active-high reset
enable  in  1  permit new triangles to be issued
in_valid  in  1  command valid
in_ready  out  1  FIFO can accept a command
in_p1  in  3*COORD_W  vertex 1 {z,y,x}, x in LSBs
in_p2  in  3*COORD_W  vertex 2
in_p3  in  3*COORD_W  vertex 3
in_last  in  1  command is the last triangle of a frame
rast_start  out  1  one-cycle start pulse to rasterizer
rast_p1  out  3*COORD_W  vertex 1 to rasterizer, held stable from START until done
rast_p2  out  3*COORD_W  vertex 2
rast_p3  out  3*COORD_W  vertex 3
rast_done  in  1  rasterizer completion (level or pulse)
busy  out  1  high outside IDLE
frame_done  out  1  one-cycle pulse when a last-flagged triangle completes
tri_count  out  CNT_W  triangles completed since reset, wraps
fifo_level  out  $clog2(DEPTH+1)  current FIFO occupancy
timeout_err  out  1  sticky watchdog flag (optional feature only)

Behaviour:
- Reset (async, immediate): state IDLE, FIFO empty, in_ready=1, rast_start=0, rast_p*=0, busy=0, frame_done=0, tri_count=0, fifo_level=0, timeout_err=0.
- Push: a command is accepted on a clk edge with in_valid&&in_ready.
  - in_ready = !full, registered-free combinational from occupancy.
  - in_ready does not depend on a same-cycle pop: when full, a simultaneous push is refused.
- FSM: IDLE -> LOAD -> START -> WAIT -> DONE -> IDLE.
  - IDLE: if enable && !empty, pop the head and go to LOAD. Otherwise stay.
  - LOAD: register the head entry into rast_p1..3 and the last flag.
  - START: rast_start=1 for exactly this cycle.
  - WAIT: stay until rast_done=1 is sampled. rast_done is ignored in all other states, including the START cycle.
  - DONE: tri_count += 1 (mod 2^CNT_W). frame_done=1 this cycle if the latched last flag is set.
- Latency: a command pushed into an empty FIFO at edge N (enable high, IDLE) is popped at N+1; rast_start is high in the cycle after edge N+2.
- Minimum spacing between consecutive rast_start pulses: 4 cycles plus the rasterizer time.
- fifo_level: +1 on push, -1 on pop, unchanged on simultaneous push and pop. Never exceeds DEPTH.
- FIFO pointers are log2(DEPTH) bits plus a wrap bit; wrap-around is seamless.
- enable dropping mid-triangle: the current triangle completes normally; no further pops until enable returns.
- rast_p* hold their last values in IDLE.
- Reset mid-operation: everything is discarded, including queued commands. A rast_done arriving after reset is ignored (the FSM is in IDLE).

Optional Feature:
Macro RASTER_SEQ_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT. On reaching TIMEOUT_CYCLES without rast_done, go to DONE as if completed.
  - timeout_err is set sticky until reset; tri_count still increments and frame_done still fires for a last-flagged entry.
- Undefined: no counter; WAIT waits indefinitely; the timeout_err port is absent.

Test Plan:
1. Reset, push one triangle (69,69,1)/(69,169,1)/(169,69,1) as 0x428a0000 etc., rasterizer model returning done 10 cycles after start -> rast_start is a single pulse 2 cycles after acceptance; rast_p* match the inputs; tri_count=1; busy returns low.
2. enable=0, push DEPTH=8 commands then a 9th -> in_ready=0 after the 8th, 9th not accepted, fifo_level=8; raise enable -> 8 start pulses in FIFO order, tri_count=8.
3. Push 3 triangles with in_last on the 3rd -> frame_done pulses exactly once, in the DONE cycle after the 3rd rast_done.
4. Assert rast_done during IDLE and the START cycle -> no state change, no count. Hold rast_done high continuously -> each triangle still gets START then exits WAIT one cycle later.
5. Assert areset during WAIT with 4 queued -> all outputs at reset values immediately; fifo_level=0; no later start without a new push.
6. With RASTER_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, never assert done -> DONE after 16 WAIT cycles, timeout_err=1 sticky, next triangle issued. Force tri_count to 0xFFFF -> next completion wraps it to 0.

Source files
------------

// File: rtl/raster_sequencer.sv
// raster_sequencer: queues triangle commands and hands them to the rasterizer
// one at a time over a start/done handshake.
//   - command FIFO of DEPTH entries (pointers carry an extra wrap bit)
//   - per-triangle FSM IDLE -> LOAD -> START -> WAIT -> DONE -> IDLE
//   - frame_done pulse for last-flagged triangles, wrapping completion counter
// Optional build macro RASTER_SEQ_TIMEOUT_EN adds a WAIT watchdog that forces
// completion after TIMEOUT_CYCLES and raises a sticky timeout_err output.

module raster_seq_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         areset,
  input  logic                         push,
  input  logic [W-1:0]                 wdata,
  input  logic                         pop,
  output logic [W-1:0]                 rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;

  // Same index with different wrap bits means the writer lapped the reader.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign level = LVL_W'(wr_ptr - rd_ptr);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Pointer update; the wrap bit makes wrap-around seamless for power-of-2 depth.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

module raster_sequencer #(
  parameter int COORD_W        = 32,
  parameter int DEPTH          = 8,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                         clk,
  input  logic                         areset,
  input  logic                         enable,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3*COORD_W-1:0]         in_p1,
  input  logic [3*COORD_W-1:0]         in_p2,
  input  logic [3*COORD_W-1:0]         in_p3,
  input  logic                         in_last,
  output logic                         rast_start,
  output logic [3*COORD_W-1:0]         rast_p1,
  output logic [3*COORD_W-1:0]         rast_p2,
  output logic [3*COORD_W-1:0]         rast_p3,
  input  logic                         rast_done,
  output logic                         busy,
  output logic                         frame_done,
  output logic [CNT_W-1:0]             tri_count,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level
`ifdef RASTER_SEQ_TIMEOUT_EN
  ,
  output logic                         timeout_err
`endif
);
  localparam int VW = 3*COORD_W;

  typedef struct packed {
    logic [VW-1:0] p1;
    logic [VW-1:0] p2;
    logic [VW-1:0] p3;
    logic          last;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state;
  cmd_t   wr_cmd, head_cmd, hold_q;
  logic   fifo_full, fifo_empty;
  logic   push, pop;
  logic   last_q;

`ifdef RASTER_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES+1);
  logic [WD_W-1:0] wd_cnt;
`endif

  // Acceptance depends only on occupancy, never on a same-cycle pop.
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = (state == S_IDLE) && enable && !fifo_empty;

  assign wr_cmd = '{p1: in_p1, p2: in_p2, p3: in_p3, last: in_last};

  raster_seq_fifo #(
    .W     ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .areset(areset),
    .push  (push),
    .wdata (wr_cmd),
    .pop   (pop),
    .rdata (head_cmd),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Triangle issue FSM; all handshake and status outputs are registered here.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state      <= S_IDLE;
      hold_q     <= '0;
      last_q     <= 1'b0;
      rast_p1    <= '0;
      rast_p2    <= '0;
      rast_p3    <= '0;
      rast_start <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      tri_count  <= '0;
`ifdef RASTER_SEQ_TIMEOUT_EN
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      rast_start <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          // Capture the head at pop time: its slot may be refilled right away.
          if (pop) begin
            hold_q <= head_cmd;
            busy   <= 1'b1;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          rast_p1    <= hold_q.p1;
          rast_p2    <= hold_q.p2;
          rast_p3    <= hold_q.p3;
          last_q     <= hold_q.last;
          rast_start <= 1'b1;
          state      <= S_START;
        end
        S_START: begin
          // rast_done here may be stale from the previous triangle; ignore it.
`ifdef RASTER_SEQ_TIMEOUT_EN
          wd_cnt <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (rast_done) begin
            tri_count  <= tri_count + 1'b1;
            frame_done <= last_q;
            state      <= S_DONE;
          end
`ifdef RASTER_SEQ_TIMEOUT_EN
          else if (wd_cnt == WD_W'(TIMEOUT_CYCLES-1)) begin
            // Treat a hung rasterizer as finished so the queue keeps draining.
            tri_count   <= tri_count + 1'b1;
            frame_done  <= last_q;
            timeout_err <= 1'b1;
            state       <= S_DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_raster_sequencer.sv
// Testbench for raster_sequencer: randomized commands, a behavioural
// rasterizer that answers rast_start after a programmable latency, and a
// queue-based reference of what should be issued and counted.
// Build with +define+RASTER_SEQ_TIMEOUT_EN to also exercise the watchdog.
`timescale 1ns/1ps
module tb_raster_sequencer;
  localparam int COORD_W = 32;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = 4;
`ifdef RASTER_SEQ_TIMEOUT_EN
  localparam int TMO     = 16;
`else
  localparam int TMO     = 1048576;
`endif
  localparam int VW      = 3*COORD_W;
  localparam int LVL_W   = $clog2(DEPTH+1);

  logic gpu_clk_150 = 1'b0;
  logic areset = 1'b1, enable = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [VW-1:0] in_p1 = '0, in_p2 = '0, in_p3 = '0;
  logic in_ready, rast_start, busy, frame_done, rast_done;
  logic model_done = 1'b0, tb_done = 1'b0;
  logic [VW-1:0] rast_p1, rast_p2, rast_p3;
  logic [CNT_W-1:0] tri_count;
  logic [LVL_W-1:0] fifo_level;
`ifdef RASTER_SEQ_TIMEOUT_EN
  logic timeout_err;
`endif

  assign rast_done = model_done | tb_done;

  raster_sequencer #(
    .COORD_W(COORD_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(gpu_clk_150), .areset(areset), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_p1(in_p1), .in_p2(in_p2), .in_p3(in_p3), .in_last(in_last),
    .rast_start(rast_start), .rast_p1(rast_p1), .rast_p2(rast_p2), .rast_p3(rast_p3),
    .rast_done(rast_done), .busy(busy), .frame_done(frame_done),
    .tri_count(tri_count), .fifo_level(fifo_level)
`ifdef RASTER_SEQ_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  initial forever #5 gpu_clk_150 = ~gpu_clk_150;

  typedef struct { logic [VW-1:0] p1, p2, p3; logic last; } cmd_t;
  typedef struct { logic [VW-1:0] p1, p2, p3; int cyc; } start_t;

  cmd_t   exp_q[$];
  start_t start_log[$];
  int errors = 0, checks = 0;
  int cyc = 0, exp_tri = 0;
  int frame_cnt = 0, frame_cyc = -1, last_done_cyc = -1, max_level = 0;
  bit model_on = 1'b0, saw_wrap = 1'b0;
  int rast_lat = 10;
  logic [CNT_W-1:0] prev_tc = '0;

  // Cycle counter, observers and rasterizer model (answers each start after rast_lat cycles).
  initial begin
    int rem;
    start_t s;
    rem = -1;
    forever begin
      @(posedge gpu_clk_150);
      cyc++;
      #2;
      if (rast_start === 1'b1) begin
        s.p1 = rast_p1; s.p2 = rast_p2; s.p3 = rast_p3; s.cyc = cyc;
        start_log.push_back(s);
      end
      if (frame_done === 1'b1) begin frame_cnt++; frame_cyc = cyc; end
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      if (prev_tc == {CNT_W{1'b1}} && tri_count == '0) saw_wrap = 1'b1;
      prev_tc = tri_count;
      if (!model_on) begin
        rem = -1; model_done = 1'b0;
      end else if (rast_start === 1'b1) begin
        rem = rast_lat; model_done = 1'b0;
      end else if (rem > 0) begin
        rem--;
        if (rem == 0) begin model_done = 1'b1; last_done_cyc = cyc; rem = -1; end
        else model_done = 1'b0;
      end else begin
        model_done = 1'b0;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge gpu_clk_150); #1; end
  endtask

  function automatic cmd_t rand_cmd(input bit last);
    cmd_t c;
    c.p1 = {$urandom(), $urandom(), $urandom()};
    c.p2 = {$urandom(), $urandom(), $urandom()};
    c.p3 = {$urandom(), $urandom(), $urandom()};
    c.last = last;
    return c;
  endfunction

  // Offer one command until accepted (bounded); returns at #1 after the accepting edge.
  task automatic push(input cmd_t c, input int budget, output bit ok);
    int n;
    n = 0;
    in_valid = 1'b1; in_p1 = c.p1; in_p2 = c.p2; in_p3 = c.p3; in_last = c.last;
    while (in_ready !== 1'b1 && n < budget) begin step(1); n++; end
    ok = (in_ready === 1'b1);
    step(1);
    in_valid = 1'b0; in_last = 1'b0;
    if (ok) exp_q.push_back(c);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n;
    n = 0;
    while (!(busy === 1'b0 && fifo_level == '0) && n < budget) begin step(1); n++; end
    ok = (n < budget);
  endtask

  task automatic test_reset();
    areset = 1'b1;
    #3;
    checks++; if (rast_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", rast_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    checks++; if (tri_count !== '0 || frame_done !== 1'b0) begin errors++; $display("FAIL reset_count: tri=%0d frame=%b want 0/0", tri_count, frame_done); end
    checks++; if ({rast_p1, rast_p2, rast_p3} !== '0) begin errors++; $display("FAIL reset_verts: got %h want 0", {rast_p1, rast_p2, rast_p3}); end
`ifdef RASTER_SEQ_TIMEOUT_EN
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_tmo: got %b want 0", timeout_err); end
`endif
    step(1);
    areset = 1'b0;
    step(2);
  endtask

  task automatic test_single();
    cmd_t c; bit ok; int acc, f0;
    start_log.delete(); exp_q.delete();
    model_on = 1'b1; rast_lat = 10; enable = 1'b1; f0 = frame_cnt;
    c.p1 = {32'h3f800000, 32'h428a0000, 32'h428a0000};
    c.p2 = {32'h3f800000, 32'h43290000, 32'h428a0000};
    c.p3 = {32'h3f800000, 32'h428a0000, 32'h43290000};
    c.last = 1'b0;
    push(c, 4, ok);
    acc = cyc;
    checks++; if (!ok) begin errors++; $display("FAIL single_accept: in_ready never high"); end
    wait_idle(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_idle: busy=%b level=%0d want idle", busy, fifo_level); end
    checks++; if (start_log.size() != 1) begin errors++; $display("FAIL single_pulses: got %0d want 1", start_log.size()); end
    if (start_log.size() >= 1) begin
      checks++; if (start_log[0].cyc != acc + 2) begin errors++; $display("FAIL single_latency: start at %0d want %0d", start_log[0].cyc, acc + 2); end
      checks++;
      if ({start_log[0].p1, start_log[0].p2, start_log[0].p3} !== {c.p1, c.p2, c.p3}) begin
        errors++; $display("FAIL single_verts: got %h want %h", {start_log[0].p1, start_log[0].p2, start_log[0].p3}, {c.p1, c.p2, c.p3});
      end
    end
    exp_tri += 1;
    checks++; if (tri_count !== CNT_W'(exp_tri)) begin errors++; $display("FAIL single_count: got %0d want %0d", tri_count, CNT_W'(exp_tri)); end
    checks++; if (frame_cnt != f0) begin errors++; $display("FAIL single_frame: got %0d pulses want 0", frame_cnt - f0); end
    checks++; if ({rast_p1, rast_p2, rast_p3} !== {c.p1, c.p2, c.p3}) begin errors++; $display("FAIL single_hold: verts changed in idle"); end
  endtask

  task automatic test_full_fifo();
    cmd_t c; bit ok; int lat;
    start_log.delete(); exp_q.delete();
    enable = 1'b0; model_on = 1'b1; max_level = 0;
    for (int i = 0; i < DEPTH; i++) begin
      push(rand_cmd(1'b0), 2, ok);
      checks++; if (!ok) begin errors++; $display("FAIL full_push%0d: refused with level=%0d", i, fifo_level); end
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", in_ready); end
    checks++; if (fifo_level !== LVL_W'(DEPTH)) begin errors++; $display("FAIL full_level: got %0d want %0d", fifo_level, DEPTH); end
    c = rand_cmd(1'b0);
    in_valid = 1'b1; in_p1 = c.p1; in_p2 = c.p2; in_p3 = c.p3;
    step(2);
    in_valid = 1'b0;
    checks++; if (fifo_level !== LVL_W'(DEPTH)) begin errors++; $display("FAIL full_overflow: level=%0d want %0d", fifo_level, DEPTH); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_disabled: busy=%b want 0", busy); end
    lat = $urandom_range(1, 6); rast_lat = lat; enable = 1'b1;
    wait_idle(1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_drain: busy=%b level=%0d", busy, fifo_level); end
    checks++; if (start_log.size() != DEPTH) begin errors++; $display("FAIL full_pulses: got %0d want %0d", start_log.size(), DEPTH); end
    for (int i = 0; i < DEPTH && i < start_log.size(); i++) begin
      checks++;
      if ({start_log[i].p1, start_log[i].p2, start_log[i].p3} !== {exp_q[i].p1, exp_q[i].p2, exp_q[i].p3}) begin
        errors++; $display("FAIL full_order%0d: got %h want %h", i, {start_log[i].p1, start_log[i].p2, start_log[i].p3}, {exp_q[i].p1, exp_q[i].p2, exp_q[i].p3});
      end
      if (i > 0) begin
        checks++;
        if (start_log[i].cyc - start_log[i-1].cyc != lat + 4) begin
          errors++; $display("FAIL full_spacing%0d: gap %0d want %0d", i, start_log[i].cyc - start_log[i-1].cyc, lat + 4);
        end
      end
    end
    exp_tri += DEPTH;
    checks++; if (tri_count !== CNT_W'(exp_tri)) begin errors++; $display("FAIL full_count: got %0d want %0d", tri_count, CNT_W'(exp_tri)); end
    checks++; if (max_level != DEPTH) begin errors++; $display("FAIL full_maxlevel: got %0d want %0d", max_level, DEPTH); end
  endtask

  task automatic test_frame();
    bit ok; int f0;
    start_log.delete(); exp_q.delete();
    enable = 1'b1; model_on = 1'b1; rast_lat = $urandom_range(2, 8); f0 = frame_cnt;
    for (int i = 0; i < 3; i++) begin
      push(rand_cmd(i == 2), 50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL frame_push%0d: refused", i); end
    end
    wait_idle(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL frame_drain: busy=%b level=%0d", busy, fifo_level); end
    checks++; if (frame_cnt - f0 != 1) begin errors++; $display("FAIL frame_pulses: got %0d want 1", frame_cnt - f0); end
    checks++; if (frame_cyc != last_done_cyc + 1) begin errors++; $display("FAIL frame_timing: pulse at %0d want %0d", frame_cyc, last_done_cyc + 1); end
    for (int i = 0; i < 3 && i < start_log.size(); i++) begin
      checks++;
      if ({start_log[i].p1, start_log[i].p2, start_log[i].p3} !== {exp_q[i].p1, exp_q[i].p2, exp_q[i].p3}) begin
        errors++; $display("FAIL frame_order%0d: got %h want %h", i, {start_log[i].p1, start_log[i].p2, start_log[i].p3}, {exp_q[i].p1, exp_q[i].p2, exp_q[i].p3});
      end
    end
    exp_tri += 3;
    checks++; if (tri_count !== CNT_W'(exp_tri)) begin errors++; $display("FAIL frame_count: got %0d want %0d", tri_count, CNT_W'(exp_tri)); end
  endtask

  task automatic test_done_ignored();
    bit ok; int chg[$]; logic [CNT_W-1:0] prev;
    start_log.delete(); exp_q.delete();
    model_on = 1'b0; enable = 1'b1; tb_done = 1'b1;
    step(5);
    checks++; if (busy !== 1'b0 || tri_count !== CNT_W'(exp_tri)) begin errors++; $display("FAIL idle_done: busy=%b tri=%0d want 0/%0d", busy, tri_count, CNT_W'(exp_tri)); end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) push(rand_cmd(1'b0), 4, ok);
    enable = 1'b1;
    prev = tri_count;
    for (int n = 0; n < 60; n++) begin
      step(1);
      if (tri_count != prev) chg.push_back(cyc);
      prev = tri_count;
    end
    tb_done = 1'b0;
    checks++; if (start_log.size() != 3 || chg.size() != 3) begin errors++; $display("FAIL hold_done_n: starts=%0d completions=%0d want 3/3", start_log.size(), chg.size()); end
    for (int i = 0; i < 3 && i < start_log.size() && i < chg.size(); i++) begin
      checks++;
      if (chg[i] != start_log[i].cyc + 2) begin errors++; $display("FAIL hold_done_exit%0d: done at %0d want %0d", i, chg[i], start_log[i].cyc + 2); end
    end
    exp_tri += 3;
    checks++; if (tri_count !== CNT_W'(exp_tri)) begin errors++; $display("FAIL hold_done_count: got %0d want %0d", tri_count, CNT_W'(exp_tri)); end
  endtask

  task automatic test_reset_mid();
    bit ok; int n, n0;
    start_log.delete(); exp_q.delete();
    model_on = 1'b1; rast_lat = 40; enable = 1'b1;
    for (int i = 0; i < 5; i++) push(rand_cmd(1'b0), 4, ok);
    n = 0;
    while (start_log.size() == 0 && n < 20) begin step(1); n++; end
    step(3);
    checks++; if (fifo_level !== LVL_W'(4) || busy !== 1'b1) begin errors++; $display("FAIL mid_prestate: level=%0d busy=%b want 4/1", fifo_level, busy); end
    #3 areset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || rast_start !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL mid_ctrl: busy=%b start=%b frame=%b want 0", busy, rast_start, frame_done); end
    checks++; if (fifo_level !== '0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_fifo: level=%0d ready=%b want 0/1", fifo_level, in_ready); end
    checks++; if (tri_count !== '0 || {rast_p1, rast_p2, rast_p3} !== '0) begin errors++; $display("FAIL mid_regs: tri=%0d verts=%h want 0", tri_count, {rast_p1, rast_p2, rast_p3}); end
    step(1);
    areset = 1'b0;
    exp_q.delete(); exp_tri = 0;
    n0 = start_log.size();
    step(60);
    checks++; if (start_log.size() != n0 || busy !== 1'b0) begin errors++; $display("FAIL mid_after: starts=%0d busy=%b want %0d/0", start_log.size(), busy, n0); end
    checks++; if (tri_count !== '0) begin errors++; $display("FAIL mid_late_done: tri=%0d want 0", tri_count); end
  endtask

  task automatic test_wrap();
    bit ok;
    start_log.delete(); exp_q.delete();
    model_on = 1'b1; rast_lat = 1; enable = 1'b1; saw_wrap = 1'b0;
    for (int i = 0; i < 18; i++) push(rand_cmd(1'b0), 100, ok);
    wait_idle(1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_drain: busy=%b level=%0d", busy, fifo_level); end
    checks++; if (start_log.size() != 18) begin errors++; $display("FAIL wrap_pulses: got %0d want 18", start_log.size()); end
    exp_tri += 18;
    checks++; if (tri_count !== CNT_W'(exp_tri)) begin errors++; $display("FAIL wrap_count: got %0d want %0d", tri_count, CNT_W'(exp_tri)); end
    checks++; if (!saw_wrap) begin errors++; $display("FAIL wrap_seen: max->0 transition not observed"); end
  endtask

`ifdef RASTER_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    bit ok; int chg[$], f0; logic [CNT_W-1:0] prev;
    start_log.delete(); exp_q.delete();
    model_on = 1'b0; tb_done = 1'b0; enable = 1'b0; f0 = frame_cnt;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_initial: got %b want 0", timeout_err); end
    push(rand_cmd(1'b0), 4, ok);
    push(rand_cmd(1'b1), 4, ok);
    enable = 1'b1;
    prev = tri_count;
    for (int n = 0; n < 80; n++) begin
      step(1);
      if (tri_count != prev) chg.push_back(cyc);
      prev = tri_count;
    end
    checks++; if (start_log.size() != 2 || chg.size() != 2) begin errors++; $display("FAIL tmo_n: starts=%0d completions=%0d want 2/2", start_log.size(), chg.size()); end
    if (start_log.size() == 2 && chg.size() == 2) begin
      checks++; if (chg[0] != start_log[0].cyc + 2 + TMO - 1) begin errors++; $display("FAIL tmo_exit: done at %0d want %0d", chg[0], start_log[0].cyc + 2 + TMO - 1); end
      checks++; if (start_log[1].cyc != chg[0] + 3) begin errors++; $display("FAIL tmo_next: start at %0d want %0d", start_log[1].cyc, chg[0] + 3); end
    end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b want 1", timeout_err); end
    checks++; if (frame_cnt - f0 != 1) begin errors++; $display("FAIL tmo_frame: got %0d want 1", frame_cnt - f0); end
    exp_tri += 2;
    checks++; if (tri_count !== CNT_W'(exp_tri)) begin errors++; $display("FAIL tmo_count: got %0d want %0d", tri_count, CNT_W'(exp_tri)); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_full_fifo();
    test_frame();
    test_done_ignored();
    test_reset_mid();
    test_wrap();
`ifdef RASTER_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
